// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo block.
package sync_fifo_pkg;

   // Count must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; slave is the FIFO side.
interface sync_fifo_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32
) ();
   import sync_fifo_pkg::*;

   localparam int unsigned CntW = count_width(DEPTH);

   logic             i_WR_EN;
   logic [WIDTH-1:0] i_WR_DATA;
   logic             o_FULL;
   logic             o_ALMOST_FULL;
   logic             i_RD_EN;
   logic [WIDTH-1:0] o_RD_DATA;
   logic             VALID;
   logic             o_EMPTY;
   logic             o_ALMOST_EMPTY;
   logic [CntW-1:0]  o_COUNT;
   logic             OF;
   logic             UF;

   modport slave (
      input  i_WR_EN, i_WR_DATA, i_RD_EN,
      output o_FULL, o_ALMOST_FULL, o_RD_DATA, VALID, o_EMPTY, o_ALMOST_EMPTY, o_COUNT, OF, UF
   );

   modport master (
      output i_WR_EN, i_WR_DATA, i_RD_EN,
      input  o_FULL, o_ALMOST_FULL, o_RD_DATA, VALID, o_EMPTY, o_ALMOST_EMPTY, o_COUNT, OF, UF
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered or combinational read.
module sync_fifo_ram #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 32,
   parameter  int unsigned FWFT  = 0,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             i_CLK,
   input  logic             i_RESET,
   input  logic             i_WR_EN,
   input  logic [AW-1:0]    i_WR_ADDR,
   input  logic [WIDTH-1:0] i_WR_DATA,
   input  logic             i_RD_EN,
   input  logic [AW-1:0]    i_RD_ADDR,
   output logic [WIDTH-1:0] o_RD_DATA
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_CLK) begin
      if (i_WR_EN) begin
         r_mem[i_WR_ADDR] <= i_WR_DATA;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         r_rd_data <= '0;
      end else if (i_RD_EN) begin
         r_rd_data <= r_mem[i_RD_ADDR];
      end
   end

   assign o_RD_DATA = (FWFT != 0) ? r_mem[i_RD_ADDR] : r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flags and overflow/underflow pulses.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DEPTH        = 32,
   parameter int unsigned ALMOST_FULL  = 30,
   parameter int unsigned ALMOST_EMPTY = 2,
   parameter int unsigned FWFT         = 0
) (
   input  logic      i_CLK,
   input  logic      i_RESET,
   sync_fifo_if.slave bus
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CntW = count_width(DEPTH);

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic [CntW-1:0]  w_count_d;
   logic             r_valid;
   logic             r_of;
   logic             r_uf;
   logic             w_full;
   logic             w_empty;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic [WIDTH-1:0] w_ram_data;

   assign w_full   = (r_count == CntW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = bus.i_RD_EN && !w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign w_wr_acc = bus.i_WR_EN && (!w_full || w_rd_acc);

   always_comb begin
      w_count_d = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_d = r_count + CntW'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_d = r_count - CntW'(1);
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_of     <= 1'b0;
         r_uf     <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_d;
         r_valid <= w_rd_acc;
         r_of    <= bus.i_WR_EN && !w_wr_acc;
         r_uf    <= bus.i_RD_EN && w_empty;
      end
   end

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .FWFT  (FWFT)
   ) u_ram (
      .i_CLK     (i_CLK),
      .i_RESET   (i_RESET),
      .i_WR_EN   (w_wr_acc),
      .i_WR_ADDR (r_wr_ptr),
      .i_WR_DATA (bus.i_WR_DATA),
      .i_RD_EN   (w_rd_acc),
      .i_RD_ADDR (r_rd_ptr),
      .o_RD_DATA (w_ram_data)
   );

   assign bus.o_FULL         = w_full;
   assign bus.o_EMPTY        = w_empty;
   assign bus.o_ALMOST_FULL  = (r_count >= CntW'(ALMOST_FULL));
   assign bus.o_ALMOST_EMPTY = (r_count <= CntW'(ALMOST_EMPTY));
   assign bus.o_COUNT        = r_count;
   assign bus.OF             = r_of;
   assign bus.UF             = r_uf;

   // FWFT shows the head word whenever one exists; zero while empty keeps the reset value.
   assign bus.VALID     = (FWFT != 0) ? !w_empty : r_valid;
   assign bus.o_RD_DATA = (FWFT != 0) ? (w_empty ? '0 : w_ram_data) : w_ram_data;

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard and an FWFT sync_fifo in lockstep and checks both against a queue model.
module tb_sync_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned AF    = 30;
   localparam int unsigned AE    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] wr_data;

   always #5 clk = ~clk;

   sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_std ();
   sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_fw ();

   assign if_std.i_WR_EN   = wr_en;
   assign if_std.i_WR_DATA = wr_data;
   assign if_std.i_RD_EN   = rd_en;
   assign if_fw.i_WR_EN    = wr_en;
   assign if_fw.i_WR_DATA  = wr_data;
   assign if_fw.i_RD_EN    = rd_en;

   sync_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .FWFT(0)
   ) u_std (
      .i_CLK   (clk),
      .i_RESET (rst_n),
      .bus     (if_std.slave)
   );

   sync_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .FWFT(1)
   ) u_fw (
      .i_CLK   (clk),
      .i_RESET (rst_n),
      .bus     (if_fw.slave)
   );

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] exp_rd;
   logic             exp_valid;
   logic             exp_of;
   logic             exp_uf;
   int               checks   = 0;
   int               failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_rd    = '0;
      exp_valid = 1'b0;
      exp_of    = 1'b0;
      exp_uf    = 1'b0;
   endtask

   task automatic model_edge();
      logic rd_ok;
      logic wr_ok;
      rd_ok     = rd_en && (q.size() > 0);
      wr_ok     = wr_en && ((q.size() < DEPTH) || rd_ok);
      exp_of    = wr_en && !wr_ok;
      exp_uf    = rd_en && !rd_ok;
      exp_valid = rd_ok;
      if (rd_ok) exp_rd = q.pop_front();
      if (wr_ok) q.push_back(wr_data);
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".cnt"},   32'(if_std.o_COUNT),        32'(n));
      chk({tag, ".empty"}, 32'(if_std.o_EMPTY),        32'(n == 0));
      chk({tag, ".full"},  32'(if_std.o_FULL),         32'(n == DEPTH));
      chk({tag, ".af"},    32'(if_std.o_ALMOST_FULL),  32'(n >= AF));
      chk({tag, ".ae"},    32'(if_std.o_ALMOST_EMPTY), 32'(n <= AE));
      chk({tag, ".of"},    32'(if_std.OF),             32'(exp_of));
      chk({tag, ".uf"},    32'(if_std.UF),             32'(exp_uf));
      chk({tag, ".valid"}, 32'(if_std.VALID),          32'(exp_valid));
      chk({tag, ".rd"},    32'(if_std.o_RD_DATA),      32'(exp_rd));
      chk({tag, ".fw_cnt"},   32'(if_fw.o_COUNT), 32'(n));
      chk({tag, ".fw_of"},    32'(if_fw.OF),      32'(exp_of));
      chk({tag, ".fw_uf"},    32'(if_fw.UF),      32'(exp_uf));
      chk({tag, ".fw_valid"}, 32'(if_fw.VALID),   32'(n > 0));
      chk({tag, ".fw_rd"},    32'(if_fw.o_RD_DATA), 32'((n > 0) ? q[0] : 8'h00));
   endtask

   task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re,
                       input string tag);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b1;
      wr_data = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_all("rst");
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b1, "uf_a");
      step(1'b0, 8'h00, 1'b1, "uf_b");

      for (int i = 0; i < 32; i++) step(1'b1, 8'h1A + 8'(i), 1'b0, "wr");
      step(1'b1, 8'($urandom), 1'b0, "of");
      for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1, "rd");
      step(1'b0, 8'h00, 1'b1, "uf");

      // Park the write pointer near the top so the mid-occupancy burst wraps it.
      for (int i = 0; i < 28; i++) step(1'b1, 8'($urandom), 1'b0, "fill");
      for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, "drain");
      for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b1, "rw_mid");

      while (q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, "fill_full");
      for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1, "rw_full");
      while (q.size() > 0) step(1'b0, 8'h00, 1'b1, "drain_all");
      step(1'b1, 8'($urandom), 1'b1, "rw_empty");

      for (int i = 0; i < 150; i++)
         step(1'($urandom_range(9, 0) < 7), 8'($urandom), 1'($urandom_range(9, 0) < 4), "rnd_w");
      for (int i = 0; i < 150; i++)
         step(1'($urandom_range(9, 0) < 4), 8'($urandom), 1'($urandom_range(9, 0) < 7), "rnd_r");

      while (q.size() > 0) step(1'b0, 8'h00, 1'b1, "pre_arst");
      for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, "fill10");
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      rd_en   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(posedge clk);
      #1;
      check_all("arst_hold");
      wr_en = 1'b0;
      rst_n = 1'b1;
      step(1'b1, 8'hC3, 1'b0, "post_wr");
      chk("post_fw_head", 32'(if_fw.o_RD_DATA), 32'h0000_00C3);
      step(1'b0, 8'h00, 1'b1, "post_rd");
      chk("post_std_data", 32'(if_std.o_RD_DATA), 32'h0000_00C3);
      step(1'b0, 8'h00, 1'b0, "idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
